// File: rtl/stage2_pool_fmap_reader.sv
// Ping-pong frame buffer for pooled feature-map points: writes whole points,
// streams samples out channel-major with a valid/ready handshake.
module stage2_pool_fmap_reader #(
   parameter int CI        = 3,
   parameter int IBW       = 19,
   parameter int FRAME_PTS = 16,
   localparam int CHW      = (CI > 1) ? $clog2(CI) : 1,
   localparam int IDXW     = (FRAME_PTS > 1) ? $clog2(FRAME_PTS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_in_valid,
   input  logic [CI*IBW-1:0]     i_in_fmap,
   input  logic                  i_ot_ready,
   output logic                  o_ot_valid,
   output logic [IBW-1:0]        o_ot_data,
   output logic [CHW-1:0]        o_ot_ch,
   output logic [IDXW-1:0]       o_ot_idx,
   output logic                  o_ot_last,
   output logic                  o_busy,
   output logic                  o_overflow
);

   localparam logic [IDXW-1:0] IDX_MAX = IDXW'(FRAME_PTS - 1);
   localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
   localparam logic [CHW-1:0]  CH_MAX  = CHW'(CI - 1);
   localparam logic [CHW-1:0]  CH_ONE  = CHW'(1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

   logic [CI*IBW-1:0] mem_r [0:1][0:FRAME_PTS-1];

   state_t            state_r, state_nxt_s;
   logic [1:0]        full_r, full_nxt_s;
   logic              wr_bank_r, wr_bank_nxt_s;
   logic [IDXW-1:0]   wr_ptr_r, wr_ptr_nxt_s;
   logic              rd_bank_r, rd_bank_nxt_s;
   logic              valid_r, valid_nxt_s;
   logic [IBW-1:0]    data_r;
   logic [CHW-1:0]    ch_r;
   logic [IDXW-1:0]   idx_r;
   logic              last_r, last_nxt_s;
   logic              busy_r;
   logic              ovf_r;

   logic              xfer_s, last_xfer_s;
   logic              wr_blocked_s, wr_en_s, drop_s;
   logic              load_s, sel_bank_s;
   logic [CHW-1:0]    sel_ch_s;
   logic [IDXW-1:0]   sel_idx_s;
   logic [CI*IBW-1:0] rd_word_s;
   logic [IBW-1:0]    data_nxt_s;

   assign xfer_s      = valid_r & i_ot_ready;
   assign last_xfer_s = xfer_s & last_r;

   // A bank being released on this edge may be written on the same edge.
   assign wr_blocked_s = full_r[wr_bank_r] & ~(last_xfer_s & (rd_bank_r == wr_bank_r));
   assign wr_en_s      = i_in_valid & ~wr_blocked_s;
   assign drop_s       = i_in_valid & wr_blocked_s;

   assign rd_word_s  = mem_r[sel_bank_s][sel_idx_s];
   assign data_nxt_s = rd_word_s[sel_ch_s*IBW +: IBW];

   // Writer pointer/bank advance and full-flag bookkeeping
   always_comb begin
      wr_ptr_nxt_s  = wr_ptr_r;
      wr_bank_nxt_s = wr_bank_r;
      full_nxt_s    = full_r;
      if (last_xfer_s) begin
         full_nxt_s[rd_bank_r] = 1'b0;
      end else begin
         full_nxt_s = full_nxt_s;
      end
      if (wr_en_s) begin
         if (wr_ptr_r == IDX_MAX) begin
            wr_ptr_nxt_s          = {IDXW{1'b0}};
            wr_bank_nxt_s         = ~wr_bank_r;
            full_nxt_s[wr_bank_r] = 1'b1;
         end else begin
            wr_ptr_nxt_s = wr_ptr_r + IDX_ONE;
         end
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
   end

   // Reader state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Reader next-state logic
   always_comb begin
      case (state_r)
         ST_IDLE: begin
            if (full_r[rd_bank_r]) begin
               state_nxt_s = ST_STREAM;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (last_xfer_s && !full_r[~rd_bank_r]) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STREAM;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Reader output logic: selects the next sample to present, or holds
   always_comb begin
      load_s        = 1'b0;
      valid_nxt_s   = valid_r;
      rd_bank_nxt_s = rd_bank_r;
      sel_bank_s    = rd_bank_r;
      sel_ch_s      = ch_r;
      sel_idx_s     = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (full_r[rd_bank_r]) begin
               load_s      = 1'b1;
               valid_nxt_s = 1'b1;
               sel_ch_s    = {CHW{1'b0}};
               sel_idx_s   = {IDXW{1'b0}};
            end else begin
               valid_nxt_s = 1'b0;
            end
         end
         ST_STREAM: begin
            if (last_xfer_s) begin
               rd_bank_nxt_s = ~rd_bank_r;
               sel_bank_s    = ~rd_bank_r;
               sel_ch_s      = {CHW{1'b0}};
               sel_idx_s     = {IDXW{1'b0}};
               load_s        = full_r[~rd_bank_r];
               valid_nxt_s   = full_r[~rd_bank_r];
            end else if (xfer_s) begin
               load_s      = 1'b1;
               valid_nxt_s = 1'b1;
               if (idx_r == IDX_MAX) begin
                  sel_ch_s  = ch_r + CH_ONE;
                  sel_idx_s = {IDXW{1'b0}};
               end else begin
                  sel_idx_s = idx_r + IDX_ONE;
               end
            end else begin
               valid_nxt_s = valid_r;
            end
         end
         default: begin
            valid_nxt_s = 1'b0;
         end
      endcase
      last_nxt_s = (sel_ch_s == CH_MAX) && (sel_idx_s == IDX_MAX);
   end

   // Registered datapath, flags and outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r   <= 1'b0;
         data_r    <= {IBW{1'b0}};
         ch_r      <= {CHW{1'b0}};
         idx_r     <= {IDXW{1'b0}};
         last_r    <= 1'b0;
         rd_bank_r <= 1'b0;
         wr_bank_r <= 1'b0;
         wr_ptr_r  <= {IDXW{1'b0}};
         full_r    <= 2'b00;
         busy_r    <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         valid_r   <= valid_nxt_s;
         if (load_s) begin
            data_r <= data_nxt_s;
            ch_r   <= sel_ch_s;
            idx_r  <= sel_idx_s;
            last_r <= last_nxt_s;
         end
         rd_bank_r <= rd_bank_nxt_s;
         wr_bank_r <= wr_bank_nxt_s;
         wr_ptr_r  <= wr_ptr_nxt_s;
         full_r    <= full_nxt_s;
         busy_r    <= |full_nxt_s;
         ovf_r     <= ovf_r | drop_s;
      end
   end

   // Bank storage; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_bank_r][wr_ptr_r] <= i_in_fmap;
      end
   end

   assign o_ot_valid = valid_r;
   assign o_ot_data  = data_r;
   assign o_ot_ch    = ch_r;
   assign o_ot_idx   = idx_r;
   assign o_ot_last  = last_r;
   assign o_busy     = busy_r;
   assign o_overflow = ovf_r;

endmodule

// File: tb/tb_stage2_pool_fmap_reader.sv
// Bench for stage2_pool_fmap_reader: directed scenarios plus random traffic,
// checked against a frame-level scoreboard model.
module tb_stage2_pool_fmap_reader;
   localparam int CI  = 3;
   localparam int IBW = 19;
   localparam int FP  = 16;
   localparam int FW  = CI * IBW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_in_valid = 1'b0;
   logic [FW-1:0] i_in_fmap = '0;
   logic          i_ot_ready = 1'b0;
   logic          o_ot_valid;
   logic [IBW-1:0] o_ot_data;
   logic [1:0]    o_ot_ch;
   logic [3:0]    o_ot_idx;
   logic          o_ot_last;
   logic          o_busy;
   logic          o_overflow;

   stage2_pool_fmap_reader #(.CI(CI), .IBW(IBW), .FRAME_PTS(FP)) dut (
      .clk(clk), .reset(reset),
      .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap), .i_ot_ready(i_ot_ready),
      .o_ot_valid(o_ot_valid), .o_ot_data(o_ot_data), .o_ot_ch(o_ot_ch),
      .o_ot_idx(o_ot_idx), .o_ot_last(o_ot_last), .o_busy(o_busy),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IBW-1:0] data;
      logic [1:0]     ch;
      logic [3:0]     idx;
      logic           last;
   } samp_t;

   samp_t         expq[$];
   logic [FW-1:0] mbank [2][FP];
   logic          mfull [2];
   int            mwb, mwp, mrb;
   logic          movf, mvalid;
   int            n_checks = 0;
   int            n_pass = 0;
   int            n_dut_xfer = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic model_reset();
      mfull[0] = 1'b0; mfull[1] = 1'b0;
      mwb = 0; mwp = 0; mrb = 0;
      movf = 1'b0; mvalid = 1'b0;
      expq.delete();
   endtask

   // A completed frame is queued as CI*FP samples in channel-major order.
   task automatic push_frame(input int b);
      samp_t s;
      logic [FW-1:0] w;
      for (int ch = 0; ch < CI; ch++) begin
         for (int ix = 0; ix < FP; ix++) begin
            w      = mbank[b][ix];
            s.data = w[ch*IBW +: IBW];
            s.ch   = 2'(ch);
            s.idx  = 4'(ix);
            s.last = (ch == CI-1) && (ix == FP-1);
            expq.push_back(s);
         end
      end
   endtask

   // Advance the model across one rising edge with the given inputs.
   task automatic model_edge(input logic v, input logic [FW-1:0] f, input logic rdy);
      logic fb [2];
      logic lastx;
      int   nrb;
      fb[0] = mfull[0]; fb[1] = mfull[1];
      lastx = 1'b0;
      if (o_ot_valid && rdy) n_dut_xfer++;
      if (mvalid && rdy && expq.size() > 0) begin
         lastx = expq[0].last;
         void'(expq.pop_front());
      end
      nrb = mrb;
      if (lastx) begin
         mfull[mrb] = 1'b0;
         nrb = 1 - mrb;
      end
      if (v) begin
         if (fb[mwb] && !(lastx && mrb == mwb)) begin
            movf = 1'b1;
         end else begin
            mbank[mwb][mwp] = f;
            if (mwp == FP-1) begin
               mfull[mwb] = 1'b1;
               push_frame(mwb);
               mwb = 1 - mwb;
               mwp = 0;
            end else begin
               mwp++;
            end
         end
      end
      mrb = nrb;
      // Output is valid after an edge iff the bank to be read was full before it.
      mvalid = fb[mrb];
   endtask

   task automatic compare_outputs();
      check_eq("valid", o_ot_valid, mvalid);
      check_eq("busy", o_busy, mfull[0] | mfull[1]);
      check_eq("overflow", o_overflow, movf);
      if (mvalid && expq.size() > 0) begin
         check_eq("data", o_ot_data, expq[0].data);
         check_eq("ch", o_ot_ch, expq[0].ch);
         check_eq("idx", o_ot_idx, expq[0].idx);
         check_eq("last", o_ot_last, expq[0].last);
      end
   endtask

   task automatic cycle(input logic v, input logic [FW-1:0] f, input logic rdy);
      @(negedge clk);
      compare_outputs();
      i_in_valid = v;
      i_in_fmap  = f;
      i_ot_ready = rdy;
      model_edge(v, f, rdy);
      @(posedge clk);
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic reset_pulse(input string tag);
      #2;
      reset = 1'b1;
      i_in_valid = 1'b0;
      i_ot_ready = 1'b0;
      #1;
      check_eq({tag, "_valid"}, o_ot_valid, 1'b0);
      check_eq({tag, "_data"}, o_ot_data, 0);
      check_eq({tag, "_ch"}, o_ot_ch, 0);
      check_eq({tag, "_idx"}, o_ot_idx, 0);
      check_eq({tag, "_last"}, o_ot_last, 1'b0);
      check_eq({tag, "_busy"}, o_busy, 1'b0);
      check_eq({tag, "_ovf"}, o_overflow, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
   endtask

   function automatic logic [FW-1:0] pat_point(input int i);
      logic [IBW-1:0] a, b, c;
      a = IBW'(i);
      b = IBW'(-i);
      c = IBW'(100 + i);
      return {c, b, a};
   endfunction

   function automatic logic [FW-1:0] rnd_point();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[FW-1:0];
   endfunction

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, rnd_point(), 1'b1);
   endtask

   initial begin
      int base;
      int k;
      logic rp [4];
      rp[0] = 1'b1; rp[1] = 1'b0; rp[2] = 1'b0; rp[3] = 1'b1;
      model_reset();
      @(posedge clk);
      reset_pulse("rst0");

      // Single frame, continuous ready
      base = n_dut_xfer;
      for (int i = 0; i < FP; i++) cycle(1'b1, pat_point(i), 1'b1);
      drain(80);
      check_eq("frame1_count", n_dut_xfer - base, 48);

      // Stalls with ready pattern 1,0,0,1
      base = n_dut_xfer;
      for (int i = 0; i < FP; i++) cycle(1'b1, rnd_point(), rp[i % 4]);
      for (int i = 0; i < 200; i++) cycle(1'b0, rnd_point(), rp[i % 4]);
      check_eq("stall_count", n_dut_xfer - base, 48);

      // Two back-to-back frames
      base = n_dut_xfer;
      for (int i = 0; i < 2*FP; i++) cycle(1'b1, pat_point(i), 1'b1);
      drain(120);
      check_eq("b2b_count", n_dut_xfer - base, 96);
      check_eq("b2b_ovf", o_overflow, 1'b0);

      // Overflow with downstream blocked
      for (int i = 0; i < 3*FP; i++) cycle(1'b1, rnd_point(), 1'b0);
      check_eq("ovf_set", o_overflow, 1'b1);
      base = n_dut_xfer;
      drain(130);
      check_eq("ovf_count", n_dut_xfer - base, 96);

      // Reset at sample 20
      for (int i = 0; i < FP; i++) cycle(1'b1, pat_point(i + 7), 1'b0);
      base = n_dut_xfer;
      k = 0;
      while (k < 200 && n_dut_xfer - base < 20) begin
         cycle(1'b0, rnd_point(), 1'b1);
         k++;
      end
      check_eq("reach_s20", n_dut_xfer - base, 20);
      reset_pulse("rst_mid");
      base = n_dut_xfer;
      for (int i = 0; i < FP; i++) cycle(1'b1, pat_point(i), 1'b1);
      drain(80);
      check_eq("post_rst_count", n_dut_xfer - base, 48);

      // Partial frame then idle
      for (int i = 0; i < FP-1; i++) cycle(1'b1, rnd_point(), 1'b1);
      drain(50);
      check_eq("partial_busy", o_busy, 1'b0);
      check_eq("partial_valid", o_ot_valid, 1'b0);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, rnd_point(), $urandom_range(0, 1) == 1);
      drain(150);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
